muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide responder for the five-stage MIPS pipeline. It accepts an operation from EX on a one-cycle `start` (or an immediate mthi/mtlo/mflo/mfhi code), holds `busy` for the operation's latency, then commits results to the HI/LO register pair read back by mfhi/mflo. The pipeline's stall unit treats `start | busy` as "HI/LO unavailable".

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–15.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low; sampled on `clk` rising edge, `reset==0` resets.
- `rs`  in  32: operand A (forwarded EX rs value).
- `rt`  in  32: operand B (forwarded EX rt value).
- `Multiop`  in  3: operation code.
  - 000 mult; 001 multu; 010 div; 011 divu.
  - 100 mthi; 101 mtlo; 110 mflo (no state change); 111 mfhi (no state change).
- `start`  in  1: launch for codes 000–011; ignored for other codes.
- `busy`  out  1: registered; high while an operation is in flight.
- `hi`  out  32: architectural HI, registered.
- `low`  out  32: architectural LO, registered.
- `done`  out  1: registered one-cycle pulse in the first cycle new HI/LO are visible.

## Operation
- States:
  - IDLE: `busy=0`.
  - RUN: `busy=1`, 4-bit down-counter active.
- IDLE → RUN on a clock edge with `start=1` and `Multiop∈{000..011}`.
  - Operands and op are latched into internal registers; later `rs`/`rt` changes have no effect.
  - Counter loads `MULT_CYCLES-1` or `DIV_CYCLES-1`.
- In RUN, the counter decrements each edge. On the edge where counter==0: commit results, return to IDLE, set `done=1` for one cycle.
- Results:
  - mult: {hi,low} = signed 64-bit rs×rt.
  - multu: {hi,low} = unsigned 64-bit rs×rt.
  - div: low = quotient truncated toward zero; hi = remainder, same sign as dividend. 0x80000000 / 0xFFFFFFFF gives low=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt==0 latched): commit nothing; hi/low keep their prior values. `busy` and `done` timing are unchanged.
- Internal datapath is free: a combinational product/quotient registered at launch, or shift-add / restoring iteration, are both acceptable. hi/low must not change before the commit edge.
- mthi/mtlo in IDLE: write rs to hi/low on that edge; no `busy`, no `done`.
- Ignored in RUN: `start` and mthi/mtlo. The stall unit guarantees neither occurs; the unit must stay robust anyway.
- mflo/mfhi never alter state.
- On reset:
  - hi=0, low=0, busy=0, done=0; state=IDLE; counter=0.
  - Any in-flight operation is discarded.
  - Reset wins over a simultaneous `start`.

## Timing
- Start sampled at edge E0, where the launch cycle is cycle 0.
- `busy=1` during cycles 1..N, where N = MULT_CYCLES or DIV_CYCLES.
- Commit at edge EN.
- Cycle N+1: `busy=0`, `done=1`, new hi/low visible.
- A back-to-back `start` in cycle N+1 is accepted. Its `busy` rises in cycle N+2.
- mthi/mtlo: value visible the cycle after the write edge. Latency 1, independent of parameters.
- Outputs are registers only; no combinational path from inputs to any output.

## Test plan
- Reset, then mult with rs=0xFFFFFFFE (-2), rt=3, start for 1 cycle:
  - `busy` high exactly 5 cycles.
  - hi/low unchanged during busy.
  - Then hi=0xFFFFFFFF, low=0xFFFFFFFA, `done` one pulse.
- multu with rs=0xFFFFFFFF, rt=2 → hi=0x00000001, low=0xFFFFFFFE after 5 busy cycles.
- div with rs=-7 (0xFFFFFFF9), rt=2 → after 10 busy cycles, low=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu by zero after mthi 0x1234 and mtlo 0x5678:
  - `busy` 10 cycles, `done` pulses.
  - hi=0x1234, low=0x5678 retained.
- Mid-run disturbances during a div:
  - Mid-run: toggle rs/rt, pulse start with mult, issue mthi. Result reflects only the original div; no extra busy period.
  - Separately, assert reset (0) in busy cycle 4 → next cycle busy=0, hi=low=0, no `done`.
- Back-to-back: mult 6×7, then div 100/7 with start in the cycle `done` is high.
  - low=42 visible one cycle.
  - Then busy for 10 cycles.
  - Then low=14, hi=2.

Source files
------------

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide responder for the MIPS pipeline: one-cycle launch, fixed
// busy latency per operation class, results committed to HI/LO on the final busy edge.
module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [2:0]  Multiop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] low,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  // 64-bit product; sign-extending for mult, zero-extending for multu.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
    sb = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
    p  = sa * sb;
    return p;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of overflowing.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    logic        neg_q;
    logic        neg_r;
    neg_q = sgn & (a[31] ^ b[31]);
    neg_r = sgn & a[31];
    ma    = (sgn & a[31]) ? (~a + 32'd1) : a;
    mb    = (sgn & b[31]) ? (~b + 32'd1) : b;
    if (mb == 32'd0) begin
      mb = 32'd1;
    end
    q = ma / mb;
    r = ma % mb;
    if (neg_q) begin
      q = ~q + 32'd1;
    end
    if (neg_r) begin
      r = ~r + 32'd1;
    end
    return {r, q};
  endfunction

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] res_q;
  logic        divz_q;

  logic [63:0] res_d;
  logic        divz_d;
  logic [3:0]  cnt_d;
  logic        launch;

  always_comb begin
    res_d  = 64'd0;
    divz_d = 1'b0;
    cnt_d  = 4'(MULT_CYCLES - 1);
    if (Multiop[1]) begin
      res_d  = div64(rs, rt, ~Multiop[0]);
      divz_d = (rt == 32'd0);
      cnt_d  = 4'(DIV_CYCLES - 1);
    end else begin
      res_d  = mul64(rs, rt, ~Multiop[0]);
    end
  end

  assign launch = (state_q == IDLE) && start && !Multiop[2];

  // Result registers hold the launch-time answer, so rs/rt may change freely in RUN.
  always_ff @(posedge clk) begin
    if (launch) begin
      res_q  <= res_d;
      divz_q <= divz_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q <= RUN;
            cnt_q   <= cnt_d;
            busy_q  <= 1'b1;
          end else if (Multiop == OP_MTHI) begin
            hi_q <= rs;
          end else if (Multiop == OP_MTLO) begin
            lo_q <= rs;
          end
        end
        RUN: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!divz_q) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign low  = lo_q;

endmodule
